baud_gen_param: RTL and testbench
=================================

Name: baud_gen_param

Overview:
- Parametrised baud/oversample tick generator for the UART path, clocked by Sys_clk. Successor to the fixed-ratio divider.
- Produces single-cycle clock-enable pulses instead of derived square-wave clocks:
  - oversample tick;
  - mid-bit sample tick;
  - bit tick.
- Divisor is runtime-loadable. Phase can be restarted by the RX start-bit detector.
- All consumers stay in the Sys_clk domain.

Parameters:
DIV_W, 12, width of divisor register and oversample counter
OVERSAMPLE, 16, oversample ticks per bit; even, >=2
DEFAULT_DIV, 325, divisor loaded at reset (tick period = DEFAULT_DIV+1 Sys_clk cycles; 50 MHz -> ~16x9600)
SUB_W, $clog2(OVERSAMPLE), width of oversample phase counter (derived, not overridden)

Ports:
Sys_clk  in  1  system clock; single clock domain; all logic on rising edge
reset  in  1  synchronous, active-high reset
en  in  1  count enable; 0 freezes all counters
div_in  in  DIV_W  new divisor value (period-1)
div_load  in  1  one-cycle strobe: latch div_in and restart phase
restart  in  1  one-cycle strobe: restart phase, keep divisor
tick_os  out  1  oversample tick, one cycle wide
tick_mid  out  1  mid-bit sample tick, one cycle wide
tick_baud  out  1  bit-boundary tick, one cycle wide
os_phase  out  SUB_W  current oversample index within bit (0..OVERSAMPLE-1)
div_cur  out  DIV_W  divisor currently in use

Behaviour:
- State registers:
  - div_reg[DIV_W];
  - os_cnt[DIV_W];
  - sub_cnt[SUB_W], which drives os_phase;
  - tick_os, tick_mid and tick_baud, all registered.
  - div_cur = div_reg.
- Reset (reset=1 at an edge):
  - div_reg <= DEFAULT_DIV;
  - os_cnt, sub_cnt <= 0;
  - all ticks <= 0.
- Priority per edge: reset > div_load > restart > en.
- div_load=1:
  - div_reg <= div_in;
  - os_cnt, sub_cnt <= 0;
  - ticks <= 0;
  - en is ignored that cycle.
- restart=1 (no div_load):
  - os_cnt, sub_cnt <= 0;
  - ticks <= 0;
  - div_reg unchanged.
- en=0 (no load/restart): counters hold, all ticks <= 0.
- en=1, os_cnt != div_reg:
  - os_cnt <= os_cnt+1;
  - ticks <= 0.
- en=1, os_cnt == div_reg (terminal):
  - os_cnt <= 0;
  - tick_os <= 1;
  - tick_mid <= (sub_cnt == OVERSAMPLE/2-1);
  - tick_baud <= (sub_cnt == OVERSAMPLE-1);
  - sub_cnt <= (sub_cnt == OVERSAMPLE-1) ? 0 : sub_cnt+1.
- Timing with divisor D held and en held high:
  - tick_os period is D+1 cycles; tick_baud period is OVERSAMPLE*(D+1).
  - tick_mid/tick_baud always coincide with a tick_os pulse; never two-cycle pulses.
- Latency from reset/load/restart release (edge 0) with en=1:
  - first tick_os is visible after edge D+1;
  - first tick_mid after edge (OVERSAMPLE/2)*(D+1);
  - first tick_baud after edge OVERSAMPLE*(D+1).
- D=0: tick_os every cycle while en=1.
- D=2^DIV_W-1: os_cnt reaches all-ones and wraps to 0 via the terminal compare; no overflow path.
- div_in changing without div_load has no effect.
- Simultaneous div_load and restart: the load wins; the result is identical to a load.
- Reset asserted mid-bit discards phase and reloads DEFAULT_DIV; no tick is emitted on the reset edge.

Test Plan:
- Reset released, en=1, no load -> tick_os first after edge 326, then every 326 cycles; tick_mid at 2608; tick_baud at 5216, then every 5216; div_cur=325.
- div_load with div_in=3, en=1 -> tick_os every 4 cycles; os_phase steps 0..15; tick_mid after edge 32; tick_baud after edge 64 and every 64.
- div_in=0 loaded, en=1 -> tick_os high every cycle; tick_baud every 16 cycles, coincident with os_phase wrap 15->0.
- D=3, restart pulsed at os_phase=5, os_cnt=2 -> ticks 0 that edge; os_phase=0; next tick_mid 32 cycles later; div_cur stays 3.
- D=3, en dropped for 10 cycles mid-count -> no ticks during the gap; os_cnt/os_phase frozen; tick sequence resumes offset by exactly 10 cycles.
- D=3, reset asserted at os_phase=9 with div_load also high -> div_cur=325, os_phase=0, all ticks 0; next tick_os 326 cycles after release.

Source files
------------

// File: rtl/baud_gen_param_if.sv
// Control/status bundle for the baud tick generator: the master drives the
// enable, divisor load and restart strobes, the slave returns the ticks.
`timescale 1ns/1ps
interface baud_gen_param_if #(
  parameter int DIV_W = 12,
  parameter int SUB_W = 4
);
  logic             en;
  logic [DIV_W-1:0] div_in;
  logic             div_load;
  logic             restart;
  logic             tick_os;
  logic             tick_mid;
  logic             tick_baud;
  logic [SUB_W-1:0] os_phase;
  logic [DIV_W-1:0] div_cur;

  modport master (
    output en, div_in, div_load, restart,
    input  tick_os, tick_mid, tick_baud, os_phase, div_cur
  );

  modport slave (
    input  en, div_in, div_load, restart,
    output tick_os, tick_mid, tick_baud, os_phase, div_cur
  );
endinterface

// File: rtl/baud_gen_param.sv
// Baud / oversample tick generator. A divisor counter produces one
// oversample tick every (div+1) cycles; a phase counter over OVERSAMPLE
// ticks flags the mid-bit and bit-boundary ticks. All outputs are
// single-cycle clock enables in the Sys_clk domain.
`timescale 1ns/1ps
module baud_gen_param #(
  parameter int DIV_W       = 12,
  parameter int OVERSAMPLE  = 16,
  parameter int DEFAULT_DIV = 325
) (
  input  logic              Sys_clk,
  input  logic              reset,
  baud_gen_param_if.slave   bus
);
  localparam int SUB_W = $clog2(OVERSAMPLE);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(OVERSAMPLE / 2 - 1);
  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] os_cnt_q, os_cnt_d;
  logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
  logic             tick_os_q, tick_os_d;
  logic             tick_mid_q, tick_mid_d;
  logic             tick_baud_q, tick_baud_d;

  // Next state: load beats restart beats enable; ticks only on terminal count
  always_comb begin
    div_d       = div_q;
    os_cnt_d    = os_cnt_q;
    sub_cnt_d   = sub_cnt_q;
    tick_os_d   = 1'b0;
    tick_mid_d  = 1'b0;
    tick_baud_d = 1'b0;
    if (bus.div_load) begin
      div_d     = bus.div_in;
      os_cnt_d  = '0;
      sub_cnt_d = '0;
    end else if (bus.restart) begin
      os_cnt_d  = '0;
      sub_cnt_d = '0;
    end else if (bus.en) begin
      if (os_cnt_q == div_q) begin
        // Terminal compare also covers the all-ones divisor: no wrap path needed
        os_cnt_d    = '0;
        tick_os_d   = 1'b1;
        tick_mid_d  = (sub_cnt_q == SUB_MID);
        tick_baud_d = (sub_cnt_q == SUB_LAST);
        sub_cnt_d   = (sub_cnt_q == SUB_LAST) ? '0 : sub_cnt_q + SUB_W'(1);
      end else begin
        os_cnt_d = os_cnt_q + DIV_W'(1);
      end
    end
  end

  // State registers with synchronous reset to the default divisor
  always_ff @(posedge Sys_clk) begin
    if (reset) begin
      div_q       <= DIV_RST;
      os_cnt_q    <= '0;
      sub_cnt_q   <= '0;
      tick_os_q   <= 1'b0;
      tick_mid_q  <= 1'b0;
      tick_baud_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      os_cnt_q    <= os_cnt_d;
      sub_cnt_q   <= sub_cnt_d;
      tick_os_q   <= tick_os_d;
      tick_mid_q  <= tick_mid_d;
      tick_baud_q <= tick_baud_d;
    end
  end

  assign bus.tick_os   = tick_os_q;
  assign bus.tick_mid  = tick_mid_q;
  assign bus.tick_baud = tick_baud_q;
  assign bus.os_phase  = sub_cnt_q;
  assign bus.div_cur   = div_q;
endmodule

// File: tb/tb_baud_gen_param.sv
// Bench for baud_gen_param: directed scenarios plus randomized stimulus,
// all checked against a model that counts enabled cycles since the last
// phase restart and derives every tick from that count arithmetically.
`timescale 1ns/1ps
module tb_baud_gen_param;
  localparam int OS = 16;

  logic Sys_clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  baud_gen_param_if #(.DIV_W(12), .SUB_W(4)) bus ();

  baud_gen_param #(.DIV_W(12), .OVERSAMPLE(16), .DEFAULT_DIV(325)) dut (
    .Sys_clk (Sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  initial Sys_clk = 1'b0;
  always #5 Sys_clk = ~Sys_clk;

  // Reference model: m_k = enabled cycles since phase start
  int   m_k;
  int   m_div;
  logic m_os, m_mid, m_baud;

  always @(posedge Sys_clk) begin
    if (reset) begin
      m_div <= 325; m_k <= 0; m_os <= 1'b0; m_mid <= 1'b0; m_baud <= 1'b0;
    end else if (bus.div_load) begin
      m_div <= int'(bus.div_in); m_k <= 0; m_os <= 1'b0; m_mid <= 1'b0; m_baud <= 1'b0;
    end else if (bus.restart) begin
      m_k <= 0; m_os <= 1'b0; m_mid <= 1'b0; m_baud <= 1'b0;
    end else if (!bus.en) begin
      m_os <= 1'b0; m_mid <= 1'b0; m_baud <= 1'b0;
    end else begin
      m_k    <= m_k + 1;
      m_os   <= ((m_k + 1) % (m_div + 1)) == 0;
      m_mid  <= (((m_k + 1) % (m_div + 1)) == 0) && ((((m_k + 1) / (m_div + 1)) % OS) == OS / 2);
      m_baud <= (((m_k + 1) % (m_div + 1)) == 0) && ((((m_k + 1) / (m_div + 1)) % OS) == 0);
    end
  end

  logic [18:0] exp_vec, got_vec;
  assign exp_vec = {m_os, m_mid, m_baud, 4'((m_k / (m_div + 1)) % OS), 12'(m_div)};
  assign got_vec = {bus.tick_os, bus.tick_mid, bus.tick_baud, bus.os_phase, bus.div_cur};

  // Drive a one-cycle divisor load; returns just after edge 0
  task automatic do_load(input logic [11:0] d);
    @(negedge Sys_clk);
    bus.div_in = d; bus.div_load = 1'b1;
    @(negedge Sys_clk);
    bus.div_load = 1'b0;
  endtask

  task automatic test_reset;
    int f_os, f_mid, f_baud, s_baud;
    f_os = -1; f_mid = -1; f_baud = -1; s_baud = -1;
    @(negedge Sys_clk);
    reset = 1'b1; bus.en = 1'b1;
    @(negedge Sys_clk);
    n_cmp++;
    if (got_vec !== {3'b000, 4'd0, 12'd325}) begin
      n_bad++; $display("FAIL reset_state got=%h exp=%h", got_vec, {3'b000, 4'd0, 12'd325});
    end
    reset = 1'b0;
    for (int i = 1; i <= 10500; i++) begin
      @(negedge Sys_clk);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_bad++; $display("FAIL reset_run cyc=%0d got=%h exp=%h", i, got_vec, exp_vec);
      end
      if (bus.tick_os && f_os < 0) f_os = i;
      if (bus.tick_mid && f_mid < 0) f_mid = i;
      if (bus.tick_baud) begin
        if (f_baud < 0) f_baud = i;
        else if (s_baud < 0) s_baud = i;
      end
    end
    n_cmp++; if (f_os !== 326) begin n_bad++; $display("FAIL rst_first_os got=%0d exp=326", f_os); end
    n_cmp++; if (f_mid !== 2608) begin n_bad++; $display("FAIL rst_first_mid got=%0d exp=2608", f_mid); end
    n_cmp++; if (f_baud !== 5216) begin n_bad++; $display("FAIL rst_first_baud got=%0d exp=5216", f_baud); end
    n_cmp++; if (s_baud !== 10432) begin n_bad++; $display("FAIL rst_second_baud got=%0d exp=10432", s_baud); end
  endtask

  task automatic test_div3;
    int n_os, f_mid, f_baud, s_baud;
    n_os = 0; f_mid = -1; f_baud = -1; s_baud = -1;
    do_load(12'd3);
    for (int i = 1; i <= 140; i++) begin
      @(negedge Sys_clk);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_bad++; $display("FAIL div3_run cyc=%0d got=%h exp=%h", i, got_vec, exp_vec);
      end
      n_cmp++;
      if (bus.tick_os !== (i % 4 == 0)) begin
        n_bad++; $display("FAIL div3_os_period cyc=%0d got=%b exp=%b", i, bus.tick_os, (i % 4 == 0));
      end
      if (bus.tick_os) n_os++;
      if (bus.tick_mid && f_mid < 0) f_mid = i;
      if (bus.tick_baud) begin
        if (f_baud < 0) f_baud = i;
        else if (s_baud < 0) s_baud = i;
      end
    end
    n_cmp++; if (n_os !== 35) begin n_bad++; $display("FAIL div3_os_count got=%0d exp=35", n_os); end
    n_cmp++; if (f_mid !== 32) begin n_bad++; $display("FAIL div3_first_mid got=%0d exp=32", f_mid); end
    n_cmp++; if (f_baud !== 64) begin n_bad++; $display("FAIL div3_first_baud got=%0d exp=64", f_baud); end
    n_cmp++; if (s_baud !== 128) begin n_bad++; $display("FAIL div3_second_baud got=%0d exp=128", s_baud); end
  endtask

  task automatic test_div0;
    int n_baud;
    n_baud = 0;
    do_load(12'd0);
    for (int i = 1; i <= 48; i++) begin
      @(negedge Sys_clk);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_bad++; $display("FAIL div0_run cyc=%0d got=%h exp=%h", i, got_vec, exp_vec);
      end
      n_cmp++;
      if (bus.tick_os !== 1'b1) begin
        n_bad++; $display("FAIL div0_os cyc=%0d got=%b exp=1", i, bus.tick_os);
      end
      n_cmp++;
      if (bus.tick_baud !== (i % 16 == 0)) begin
        n_bad++; $display("FAIL div0_baud cyc=%0d got=%b exp=%b", i, bus.tick_baud, (i % 16 == 0));
      end
      if (bus.tick_baud) begin
        n_baud++;
        n_cmp++;
        if (bus.os_phase !== 4'd0) begin
          n_bad++; $display("FAIL div0_wrap cyc=%0d got=%0d exp=0", i, bus.os_phase);
        end
      end
    end
    n_cmp++; if (n_baud !== 3) begin n_bad++; $display("FAIL div0_baud_count got=%0d exp=3", n_baud); end
  endtask

  task automatic test_restart;
    int f_mid;
    f_mid = -1;
    do_load(12'd3);
    for (int i = 1; i <= 22; i++) begin
      @(negedge Sys_clk);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_bad++; $display("FAIL rs_pre cyc=%0d got=%h exp=%h", i, got_vec, exp_vec);
      end
    end
    n_cmp++;
    if (bus.os_phase !== 4'd5) begin n_bad++; $display("FAIL rs_phase5 got=%0d exp=5", bus.os_phase); end
    bus.restart = 1'b1;
    @(negedge Sys_clk);
    bus.restart = 1'b0;
    n_cmp++;
    if (got_vec !== {3'b000, 4'd0, 12'd3}) begin
      n_bad++; $display("FAIL rs_state got=%h exp=%h", got_vec, {3'b000, 4'd0, 12'd3});
    end
    for (int i = 1; i <= 40; i++) begin
      @(negedge Sys_clk);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_bad++; $display("FAIL rs_post cyc=%0d got=%h exp=%h", i, got_vec, exp_vec);
      end
      if (bus.tick_mid && f_mid < 0) f_mid = i;
    end
    n_cmp++; if (f_mid !== 32) begin n_bad++; $display("FAIL rs_next_mid got=%0d exp=32", f_mid); end
  endtask

  task automatic test_en_gap;
    int e, f_mid, f_baud;
    e = 0; f_mid = -1; f_baud = -1;
    do_load(12'd3);
    for (int i = 1; i <= 13; i++) begin
      @(negedge Sys_clk); e++;
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_bad++; $display("FAIL gap_pre cyc=%0d got=%h exp=%h", e, got_vec, exp_vec);
      end
    end
    bus.en = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge Sys_clk); e++;
      n_cmp++;
      if (got_vec[18:12] !== {3'b000, 4'd3}) begin
        n_bad++; $display("FAIL gap_frozen cyc=%0d got=%h exp=%h", e, got_vec[18:12], {3'b000, 4'd3});
      end
    end
    bus.en = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge Sys_clk); e++;
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_bad++; $display("FAIL gap_post cyc=%0d got=%h exp=%h", e, got_vec, exp_vec);
      end
      if (bus.tick_mid && f_mid < 0) f_mid = e;
      if (bus.tick_baud && f_baud < 0) f_baud = e;
    end
    n_cmp++; if (f_mid !== 42) begin n_bad++; $display("FAIL gap_mid got=%0d exp=42", f_mid); end
    n_cmp++; if (f_baud !== 74) begin n_bad++; $display("FAIL gap_baud got=%0d exp=74", f_baud); end
  endtask

  task automatic test_reset_mid;
    int f_os;
    f_os = -1;
    do_load(12'd3);
    for (int i = 1; i <= 36; i++) begin
      @(negedge Sys_clk);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_bad++; $display("FAIL rm_pre cyc=%0d got=%h exp=%h", i, got_vec, exp_vec);
      end
    end
    n_cmp++;
    if (bus.os_phase !== 4'd9) begin n_bad++; $display("FAIL rm_phase9 got=%0d exp=9", bus.os_phase); end
    reset = 1'b1; bus.div_load = 1'b1; bus.div_in = 12'd7;
    @(negedge Sys_clk);
    reset = 1'b0; bus.div_load = 1'b0;
    n_cmp++;
    if (got_vec !== {3'b000, 4'd0, 12'd325}) begin
      n_bad++; $display("FAIL rm_state got=%h exp=%h", got_vec, {3'b000, 4'd0, 12'd325});
    end
    for (int i = 1; i <= 400; i++) begin
      @(negedge Sys_clk);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_bad++; $display("FAIL rm_post cyc=%0d got=%h exp=%h", i, got_vec, exp_vec);
      end
      if (bus.tick_os && f_os < 0) f_os = i;
    end
    n_cmp++; if (f_os !== 326) begin n_bad++; $display("FAIL rm_next_os got=%0d exp=326", f_os); end
  endtask

  task automatic test_max_div;
    int f_os;
    f_os = -1;
    do_load(12'hFFF);
    for (int i = 1; i <= 4100; i++) begin
      @(negedge Sys_clk);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_bad++; $display("FAIL max_run cyc=%0d got=%h exp=%h", i, got_vec, exp_vec);
      end
      if (bus.tick_os && f_os < 0) f_os = i;
    end
    n_cmp++; if (f_os !== 4096) begin n_bad++; $display("FAIL max_first_os got=%0d exp=4096", f_os); end
  endtask

  task automatic test_random;
    do_load(12'd2);
    for (int i = 1; i <= 3000; i++) begin
      @(negedge Sys_clk);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_bad++; $display("FAIL rand cyc=%0d got=%h exp=%h", i, got_vec, exp_vec);
      end
      bus.en       = ($urandom_range(0, 9) != 0);
      bus.div_in   = 12'($urandom);
      bus.div_load = ($urandom_range(0, 199) == 0) || (i % 997 == 0);
      if (bus.div_load) bus.div_in = 12'($urandom_range(0, 5));
      bus.restart  = ($urandom_range(0, 149) == 0) || (i % 997 == 0);
      reset        = ($urandom_range(0, 999) == 0);
    end
    @(negedge Sys_clk);
    bus.en = 1'b1; bus.div_load = 1'b0; bus.restart = 1'b0; reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1;
    bus.en = 1'b1; bus.div_in = '0; bus.div_load = 1'b0; bus.restart = 1'b0;
    test_reset;
    test_div3;
    test_div0;
    test_restart;
    test_en_gap;
    test_reset_mid;
    test_max_div;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
